// File: rtl/lt24_pkg.sv
// Shared types and constants for the LT24 parallel LCD bus arbiter.
package lt24_pkg;

    localparam int unsigned DATA_W = 16;

    // LT24 (ILI9341) commands commonly issued over the bus
    localparam logic [15:0] CMD_CASET = 16'h002A;
    localparam logic [15:0] CMD_PASET = 16'h002B;
    localparam logic [15:0] CMD_RAMWR = 16'h002C;

    // Register-select encoding on lcd_rs
    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WR_LOW,
        WR_HIGH,
        NEXT,
        GAP
    } state_e;

endpackage

// File: rtl/lt24_bus_arbiter_if.sv
// Requester handshakes plus the LT24 pin bundle seen by the arbiter.
interface lt24_bus_arbiter_if #(
    parameter int unsigned DATA_W = lt24_pkg::DATA_W
) ();

    logic              s0_valid;
    logic              s0_ready;
    logic              s0_rs;
    logic [DATA_W-1:0] s0_data;
    logic              s0_last;

    logic              s1_valid;
    logic              s1_ready;
    logic              s1_rs;
    logic [DATA_W-1:0] s1_data;
    logic              s1_last;

    logic              lcd_cs_n;
    logic              lcd_rs;
    logic              lcd_rd_n;
    logic              lcd_wr_n;
    logic [DATA_W-1:0] lcd_data;
    logic              busy;
    logic              grant;

    // Requester/observer side
    modport master (
        output s0_valid, s0_rs, s0_data, s0_last,
        output s1_valid, s1_rs, s1_data, s1_last,
        input  s0_ready, s1_ready,
        input  lcd_cs_n, lcd_rs, lcd_rd_n, lcd_wr_n, lcd_data,
        input  busy, grant
    );

    // Arbiter side
    modport slave (
        input  s0_valid, s0_rs, s0_data, s0_last,
        input  s1_valid, s1_rs, s1_data, s1_last,
        output s0_ready, s1_ready,
        output lcd_cs_n, lcd_rs, lcd_rd_n, lcd_wr_n, lcd_data,
        output busy, grant
    );

endinterface

// File: rtl/lt24_rr_arbiter.sv
// Two-way round-robin arbiter; the grant is frozen while locked and the
// priority pointer moves to the other port when a transaction ends.
module lt24_rr_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       lock,
    input  logic       done,
    input  logic       owner,
    output logic       gnt_c,
    output logic       gnt_valid_c
);

    logic ptr_q;

    // Pointer favours the port that did not just finish
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else if (done) begin
            ptr_q <= ~owner;
        end
    end

    // Grant selection: single requester wins outright, contention uses pointer
    always_comb begin
        gnt_valid_c = ~lock & (|req);
        gnt_c       = ptr_q;
        if (lock) begin
            gnt_c = owner;
        end else begin
            case (req)
                2'b01:   gnt_c = 1'b0;
                2'b10:   gnt_c = 1'b1;
                default: gnt_c = ptr_q;
            endcase
        end
    end

endmodule

// File: rtl/lt24_bus_arbiter.sv
// Shares the LT24 8080-style write bus between two requesters, one whole
// transaction at a time, and generates wr_n strobe timing for every beat.
module lt24_bus_arbiter #(
    parameter int unsigned WR_LOW_CYCLES  = 2,
    parameter int unsigned WR_HIGH_CYCLES = 2,
    parameter int unsigned DATA_W         = lt24_pkg::DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    lt24_bus_arbiter_if.slave  bus
);

    import lt24_pkg::*;

    localparam int unsigned CNT_MAX   = (WR_LOW_CYCLES > WR_HIGH_CYCLES) ? WR_LOW_CYCLES
                                                                         : WR_HIGH_CYCLES;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(WR_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(WR_HIGH_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              grant_q, grant_d;
    logic              busy_q, busy_d;
    logic              cs_n_q, cs_n_d;
    logic              wr_n_q, wr_n_d;
    logic              rs_q, rs_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic [1:0]        req;
    logic              arb_gnt;
    logic              arb_gnt_valid;
    logic              s0_ready_c;
    logic              s1_ready_c;
    logic              accept;
    logic              acc_port;
    logic              acc_rs;
    logic              acc_last;
    logic [DATA_W-1:0] acc_data;

    assign req = {bus.s1_valid, bus.s0_valid};

    lt24_rr_arbiter u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .lock        (state_q != IDLE),
        .done        (state_q == GAP),
        .owner       (grant_q),
        .gnt_c       (arb_gnt),
        .gnt_valid_c (arb_gnt_valid)
    );

    // Beat acceptance: arbitration in IDLE, owner-only continuation in NEXT
    always_comb begin
        s0_ready_c = 1'b0;
        s1_ready_c = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    s0_ready_c = arb_gnt_valid & ~arb_gnt;
                    s1_ready_c = arb_gnt_valid &  arb_gnt;
                end
                NEXT: begin
                    s0_ready_c = bus.s0_valid & ~grant_q;
                    s1_ready_c = bus.s1_valid &  grant_q;
                end
                default: begin
                    s0_ready_c = 1'b0;
                    s1_ready_c = 1'b0;
                end
            endcase
        end
    end

    assign accept   = s0_ready_c | s1_ready_c;
    assign acc_port = s1_ready_c;
    assign acc_rs   = acc_port ? bus.s1_rs   : bus.s0_rs;
    assign acc_last = acc_port ? bus.s1_last : bus.s0_last;
    assign acc_data = acc_port ? bus.s1_data : bus.s0_data;

    // Next state, strobe counter and pin values decoded from the next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        rs_d    = rs_q;
        last_d  = last_q;
        data_d  = data_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                    grant_d = acc_port;
                    rs_d    = acc_rs;
                    last_d  = acc_last;
                    data_d  = acc_data;
                end
            end
            SETUP: begin
                state_d = WR_LOW;
                cnt_d   = LOW_LOAD;
            end
            WR_LOW: begin
                if (cnt_q == '0) begin
                    state_d = WR_HIGH;
                    cnt_d   = HIGH_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_HIGH: begin
                if (cnt_q == '0) begin
                    state_d = last_q ? GAP : NEXT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            NEXT: begin
                if (accept) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                    rs_d    = acc_rs;
                    last_d  = acc_last;
                    data_d  = acc_data;
                end
            end
            GAP: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        cs_n_d = (state_d == IDLE) || (state_d == GAP);
        wr_n_d = (state_d != WR_LOW);
        busy_d = (state_d != IDLE);
    end

    // State and registered pin drivers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= 1'b0;
            busy_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            rs_q    <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            cs_n_q  <= cs_n_d;
            wr_n_q  <= wr_n_d;
            rs_q    <= rs_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign bus.s0_ready = s0_ready_c;
    assign bus.s1_ready = s1_ready_c;
    assign bus.lcd_cs_n = cs_n_q;
    assign bus.lcd_wr_n = wr_n_q;
    assign bus.lcd_rs   = rs_q;
    assign bus.lcd_data = data_q;
    assign bus.lcd_rd_n = 1'b1;   // write-only bus: read strobe tied inactive
    assign bus.busy     = busy_q;
    assign bus.grant    = grant_q;

endmodule

// File: tb/tb_lt24_bus_arbiter.sv
// Directed bench for lt24_bus_arbiter: default timing instance plus a
// WR_LOW_CYCLES=WR_HIGH_CYCLES=1 instance for the throughput case.
module tb_lt24_bus_arbiter;

    import lt24_pkg::*;

    logic clk;
    logic reset;

    int n_tests;
    int n_fail;

    lt24_bus_arbiter_if bus_a ();
    lt24_bus_arbiter_if bus_b ();

    lt24_bus_arbiter u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    lt24_bus_arbiter #(
        .WR_LOW_CYCLES  (1),
        .WR_HIGH_CYCLES (1),
        .DATA_W         (16)
    ) u_dut_fast (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    logic [15:0] t3_data [3] = '{CMD_CASET, 16'h0000, 16'h00EF};
    logic [15:0] t6_data [4] = '{CMD_RAMWR, 16'hF800, 16'h07E0, 16'h001F};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_a.s0_valid = 1'b0; bus_a.s0_rs = 1'b0; bus_a.s0_data = '0; bus_a.s0_last = 1'b0;
        bus_a.s1_valid = 1'b0; bus_a.s1_rs = 1'b0; bus_a.s1_data = '0; bus_a.s1_last = 1'b0;
        bus_b.s0_valid = 1'b0; bus_b.s0_rs = 1'b0; bus_b.s0_data = '0; bus_b.s0_last = 1'b0;
        bus_b.s1_valid = 1'b0; bus_b.s1_rs = 1'b0; bus_b.s1_data = '0; bus_b.s1_last = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus_a.busy && n < 40) begin
            step();
            n++;
        end
        chk(tag, 32'(bus_a.busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        idle_inputs();
        step();
        step();

        // Reset state; ready held low even with requests pending
        bus_a.s0_valid = 1'b1;
        bus_a.s1_valid = 1'b1;
        #1;
        chk("rst_s0_ready", 32'(bus_a.s0_ready), 0);
        chk("rst_s1_ready", 32'(bus_a.s1_ready), 0);
        chk("rst_cs_n",     32'(bus_a.lcd_cs_n), 1);
        chk("rst_wr_n",     32'(bus_a.lcd_wr_n), 1);
        chk("rst_rd_n",     32'(bus_a.lcd_rd_n), 1);
        chk("rst_rs",       32'(bus_a.lcd_rs), 0);
        chk("rst_data",     32'(bus_a.lcd_data), 0);
        chk("rst_busy",     32'(bus_a.busy), 0);
        chk("rst_grant",    32'(bus_a.grant), 0);
        idle_inputs();
        reset = 1'b0;
        step();

        // Test 1: single command beat from s0
        bus_a.s0_valid = 1'b1;
        bus_a.s0_rs    = RS_CMD;
        bus_a.s0_data  = CMD_RAMWR;
        bus_a.s0_last  = 1'b1;
        #1;
        chk("t1_s0_ready_c0", 32'(bus_a.s0_ready), 1);
        step();
        bus_a.s0_valid = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            chk($sformatf("t1_cs_n_c%0d", c), 32'(bus_a.lcd_cs_n), (c <= 5) ? 0 : 1);
            chk($sformatf("t1_wr_n_c%0d", c), 32'(bus_a.lcd_wr_n), (c == 2 || c == 3) ? 0 : 1);
            chk($sformatf("t1_busy_c%0d", c), 32'(bus_a.busy), (c <= 6) ? 1 : 0);
            chk($sformatf("t1_rd_n_c%0d", c), 32'(bus_a.lcd_rd_n), 1);
            if (c <= 5) begin
                chk($sformatf("t1_data_c%0d", c), 32'(bus_a.lcd_data), 32'h002C);
                chk($sformatf("t1_rs_c%0d", c), 32'(bus_a.lcd_rs), 0);
            end
            step();
        end

        // Test 2: both ports contend after reset; grants alternate 0,1,0,1
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        bus_a.s0_valid = 1'b1; bus_a.s0_rs = RS_CMD;  bus_a.s0_data = CMD_CASET; bus_a.s0_last = 1'b1;
        bus_a.s1_valid = 1'b1; bus_a.s1_rs = RS_DATA; bus_a.s1_data = 16'hBEEF;  bus_a.s1_last = 1'b1;
        #1;
        begin
            int exp_order [4] = '{0, 1, 0, 1};
            int ng;
            int hi_run;
            int chk_g;
            bit seen_low;
            ng = 0; hi_run = 0; chk_g = -1; seen_low = 1'b0;
            for (int cyc = 0; cyc < 60 && ng < 4; cyc++) begin
                if (chk_g >= 0) begin
                    chk($sformatf("t2_grant_reg%0d", ng - 1), 32'(bus_a.grant), 32'(chk_g));
                    chk_g = -1;
                end
                if (bus_a.s0_ready || bus_a.s1_ready) begin
                    chk($sformatf("t2_ready%0d", ng), 32'({bus_a.s1_ready, bus_a.s0_ready}),
                        (exp_order[ng] == 0) ? 1 : 2);
                    chk_g = exp_order[ng];
                    ng++;
                end
                if (bus_a.lcd_cs_n) begin
                    hi_run++;
                end else begin
                    if (seen_low && hi_run > 0)
                        chk("t2_cs_high_gap", 32'(hi_run >= 2), 1);
                    seen_low = 1'b1;
                    hi_run   = 0;
                end
                step();
            end
            chk("t2_num_grants", 32'(ng), 4);
            if (chk_g >= 0)
                chk("t2_grant_reg_last", 32'(bus_a.grant), 32'(chk_g));
        end
        idle_inputs();
        wait_idle("t2_idle");
        step();

        // Test 3: s1 three-beat transaction locks out s0 until GAP
        begin
            int b;
            bit gap_seen;
            bit s0_done;
            b = 0; gap_seen = 1'b0; s0_done = 1'b0;
            for (int cyc = 0; cyc < 80 && !s0_done; cyc++) begin
                bus_a.s1_valid = (b < 3);
                if (b < 3) begin
                    bus_a.s1_data = t3_data[b];
                    bus_a.s1_rs   = (b == 0) ? RS_CMD : RS_DATA;
                    bus_a.s1_last = (b == 2);
                end
                bus_a.s0_valid = (b >= 2);
                bus_a.s0_rs    = RS_CMD;
                bus_a.s0_data  = CMD_RAMWR;
                bus_a.s0_last  = 1'b1;
                #1;
                if (b >= 1 && b <= 2)
                    chk($sformatf("t3_cs_low_cyc%0d", cyc), 32'(bus_a.lcd_cs_n), 0);
                if (bus_a.s0_valid && !gap_seen)
                    chk($sformatf("t3_s0_locked_cyc%0d", cyc), 32'(bus_a.s0_ready), 0);
                if (b == 3 && !gap_seen && bus_a.busy && bus_a.lcd_cs_n)
                    gap_seen = 1'b1;
                if (bus_a.s0_ready) begin
                    chk("t3_s0_after_gap", 32'(gap_seen), 1);
                    chk("t3_s0_in_idle", 32'(bus_a.busy), 0);
                    s0_done = 1'b1;
                end
                if (bus_a.s1_ready)
                    b++;
                @(posedge clk);
                #1;
            end
            chk("t3_s1_beats", 32'(b), 3);
            chk("t3_s0_granted", 32'(s0_done), 1);
        end
        idle_inputs();
        chk("t3_grant_s0", 32'(bus_a.grant), 0);
        chk("t3_busy_s0", 32'(bus_a.busy), 1);
        wait_idle("t3_idle");
        step();

        // Test 4: s1 holds the bus in NEXT with valid low for 10 cycles
        bus_a.s1_valid = 1'b1; bus_a.s1_rs = RS_CMD; bus_a.s1_data = CMD_PASET; bus_a.s1_last = 1'b0;
        #1;
        chk("t4_s1_ready_c0", 32'(bus_a.s1_ready), 1);
        step();
        bus_a.s1_valid = 1'b0;
        for (int c = 1; c < 6; c++) step();
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("t4_gap_cs_n%0d", c), 32'(bus_a.lcd_cs_n), 0);
            chk($sformatf("t4_gap_wr_n%0d", c), 32'(bus_a.lcd_wr_n), 1);
            chk($sformatf("t4_gap_data%0d", c), 32'(bus_a.lcd_data), 32'h002B);
            step();
        end
        chk("t4_still_busy", 32'(bus_a.busy), 1);
        bus_a.s1_valid = 1'b1; bus_a.s1_rs = RS_DATA; bus_a.s1_data = 16'h0055; bus_a.s1_last = 1'b1;
        #1;
        chk("t4_resume_ready", 32'(bus_a.s1_ready), 1);
        step();
        bus_a.s1_valid = 1'b0;
        chk("t4_setup_cs_n", 32'(bus_a.lcd_cs_n), 0);
        chk("t4_setup_wr_n", 32'(bus_a.lcd_wr_n), 1);
        chk("t4_setup_data", 32'(bus_a.lcd_data), 32'h0055);
        chk("t4_setup_rs",   32'(bus_a.lcd_rs), 1);
        step();
        chk("t4_wr_low", 32'(bus_a.lcd_wr_n), 0);
        wait_idle("t4_idle");
        step();

        // Test 5: reset during WR_LOW abandons the beat
        bus_a.s1_valid = 1'b1; bus_a.s1_rs = RS_DATA; bus_a.s1_data = 16'h1234; bus_a.s1_last = 1'b1;
        #1;
        chk("t5_s1_ready_c0", 32'(bus_a.s1_ready), 1);
        step();
        bus_a.s1_valid = 1'b0;
        step();
        chk("t5_in_wr_low", 32'(bus_a.lcd_wr_n), 0);
        reset = 1'b1;
        bus_a.s0_valid = 1'b1;
        bus_a.s1_valid = 1'b1;
        #1;
        chk("t5_rst_s0_ready", 32'(bus_a.s0_ready), 0);
        chk("t5_rst_s1_ready", 32'(bus_a.s1_ready), 0);
        step();
        chk("t5_rst_cs_n",  32'(bus_a.lcd_cs_n), 1);
        chk("t5_rst_wr_n",  32'(bus_a.lcd_wr_n), 1);
        chk("t5_rst_data",  32'(bus_a.lcd_data), 0);
        chk("t5_rst_busy",  32'(bus_a.busy), 0);
        chk("t5_rst_grant", 32'(bus_a.grant), 0);
        reset = 1'b0;
        bus_a.s0_valid = 1'b0;
        bus_a.s1_data  = 16'h5678;
        #1;
        chk("t5_new_ready", 32'(bus_a.s1_ready), 1);
        step();
        bus_a.s1_valid = 1'b0;
        chk("t5_new_grant", 32'(bus_a.grant), 1);
        chk("t5_new_busy",  32'(bus_a.busy), 1);
        chk("t5_new_cs_n",  32'(bus_a.lcd_cs_n), 0);
        chk("t5_new_data",  32'(bus_a.lcd_data), 32'h5678);
        wait_idle("t5_idle");

        // Test 6: 1/1 strobe timing, four beats, continuous valid
        begin
            int b;
            int rises;
            int lows;
            logic prev_wr;
            b = 0; rises = 0; lows = 0; prev_wr = 1'b1;
            for (int cyc = 0; cyc < 24; cyc++) begin
                bus_b.s0_valid = (b < 4);
                if (b < 4) begin
                    bus_b.s0_data = t6_data[b];
                    bus_b.s0_rs   = (b == 0) ? RS_CMD : RS_DATA;
                    bus_b.s0_last = (b == 3);
                end
                #1;
                if (bus_b.s0_ready) begin
                    chk($sformatf("t6_accept%0d_cycle", b), 32'(cyc), 32'(b * 4));
                    b++;
                end
                if (!bus_b.lcd_wr_n) begin
                    lows++;
                    if (rises < 4)
                        chk($sformatf("t6_strobe_data%0d", rises), 32'(bus_b.lcd_data),
                            32'(t6_data[rises]));
                end
                if (!prev_wr && bus_b.lcd_wr_n)
                    rises++;
                prev_wr = bus_b.lcd_wr_n;
                step();
            end
            chk("t6_beats",    32'(b), 4);
            chk("t6_wr_rises", 32'(rises), 4);
            chk("t6_wr_lows",  32'(lows), 4);
            chk("t6_idle",     32'(bus_b.busy), 0);
            chk("t6_cs_n_end", 32'(bus_b.lcd_cs_n), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lt24_bus_arbiter.md
Name: lt24_bus_arbiter

Overview:
Shares the LT24 8080-style parallel LCD bus (cs_n, rs, rd_n, wr_n, data[15:0]) between two write requesters: port 0 (Nios register path) and port 1 (hardware pixel streamer).
- Arbitrates per transaction: a command plus its parameters or pixels, terminated by a beat with last=1. Transactions are never interleaved.
- Generates write-strobe timing for every beat.
- Sits between the SOPC fabric/streamer and the LT24 pins, alongside the existing LT24 controller conduit.

Parameters:
WR_LOW_CYCLES, 2, clk cycles wr_n is held low per beat (legal >=1)
WR_HIGH_CYCLES, 2, clk cycles wr_n is held high after the rising edge per beat (legal >=1)
DATA_W, 16, LCD bus width

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
s0_valid  in  1  port 0 beat valid
s0_ready  out  1  port 0 beat accepted this cycle
s0_rs  in  1  port 0 beat type: 0=command, 1=data
s0_data  in  DATA_W  port 0 beat payload
s0_last  in  1  port 0 final beat of transaction
s1_valid / s1_ready / s1_rs / s1_data / s1_last  same widths and meaning for port 1
lcd_cs_n  out  1  LT24 chip select, active low
lcd_rs  out  1  LT24 register select
lcd_rd_n  out  1  LT24 read strobe, held 1 (write-only)
lcd_wr_n  out  1  LT24 write strobe, active low
lcd_data  out  DATA_W  LT24 data bus
busy  out  1  FSM not in IDLE
grant  out  1  owning port index; valid while busy

Behaviour:
- All lcd_* outputs, busy and grant are registered. sN_ready is combinational from state, grant and valid, and is forced to 0 while reset=1.
- Reset (clk edge with reset=1):
  - state=IDLE, lcd_cs_n=1, lcd_wr_n=1, lcd_rd_n=1, lcd_rs=0, lcd_data=0, busy=0, grant=0, rr pointer=0.
  - Reset mid-transaction abandons the transaction; no further strobes are issued. The requester must resend.
- States: IDLE, SETUP, WR_LOW, WR_HIGH, NEXT, GAP.
- IDLE:
  - Only s0 valid → grant 0. Only s1 valid → grant 1.
  - Both valid → grant the port indicated by the rr pointer.
  - The granted port sees ready=1 in that same cycle (beat accepted). rs/data/last are captured at the edge and the FSM goes to SETUP.
- SETUP (1 cycle): cs_n=0, wr_n=1, rs/data driven from the captured beat.
- WR_LOW (WR_LOW_CYCLES): wr_n=0. Then WR_HIGH (WR_HIGH_CYCLES): wr_n=1.
- rs and data are stable from SETUP through the end of WR_HIGH. The LCD samples on the wr_n rising edge.
- End of WR_HIGH:
  - Captured last=1 → GAP.
  - Otherwise → NEXT.
- NEXT:
  - cs_n stays 0. Only the granted port may be accepted (ready=valid).
  - On accept → SETUP. Valid gaps are allowed indefinitely with cs_n held low.
  - The other port's ready stays 0 even if valid.
- GAP (1 cycle): cs_n=1, no accept. The rr pointer is set to the port that did not just finish. Then → IDLE.
- Throughput: beat period = 2 + WR_LOW_CYCLES + WR_HIGH_CYCLES cycles (6 at defaults) with valid held high.
- Minimum cs_n-high time between transactions: GAP + IDLE = 2 cycles.
- Strobe counter width: $clog2(max(WR_LOW_CYCLES,WR_HIGH_CYCLES)+1). It reloads on every state entry.
- No starvation: a port waiting at end of transaction always wins the next arbitration.
- lcd_rd_n is never driven 0.

Decomposition:
- Shared package lt24_pkg:
  - state enum
  - DATA_W default
  - LT24 command constants: CMD_CASET=16'h002A, CMD_PASET=16'h002B, CMD_RAMWR=16'h002C
  - RS_CMD=0, RS_DATA=1
- One sub-module: lt24_rr_arbiter. A 2-way round-robin with lock input, giving grant and the pointer update on transaction end.
- The strobe FSM and counter stay in the top.

Test Plan:
- Single beat: s0 valid at cycle 0 in IDLE, data=16'h002C, rs=0, last=1.
  → s0_ready=1 at cycle 0; cs_n=0 cycles 1-5; wr_n=0 cycles 2-3; data=002C, rs=0 cycles 1-5; cs_n=1 cycle 6; busy=1 cycles 1-6; IDLE at cycle 7.
- Simultaneous requests after reset: s0 and s1 both valid with single-beat transactions, held asserted.
  → grant order 0,1,0,1; each transaction separated by >=2 cs_n-high cycles.
- Lock: s1 sends a 3-beat transaction (002A, then 0000, then 00EF, last on the third). s0 raises valid during the second beat.
  → s0_ready stays 0 until s1's GAP; s0 is then granted; cs_n stays low across all 3 s1 beats.
- Valid gap: s1 drops valid for 10 cycles in NEXT mid-transaction.
  → cs_n stays 0, wr_n stays 1, no strobes; the next beat resumes with SETUP.
- Reset mid-operation: assert reset during WR_LOW of a beat.
  → next edge cs_n=1, wr_n=1, data=0, busy=0, ready=0; after reset, a new s1 request is granted normally.
- Parameters WR_LOW_CYCLES=1, WR_HIGH_CYCLES=1: 4-beat s0 transaction with continuous valid.
  → beat period 4 cycles; wr_n low exactly 1 cycle per beat; 4 wr_n rising edges total.
